systolic_feeder_2x2: RTL and testbench
======================================

# systolic_feeder_2x2

Operand scheduler and result collector for the 2x2 output-stationary systolic array. It accepts matrices A and B (2x2 each) over a write port, then clears the array's accumulators. It drives the skewed row and column operand streams into the array and captures the four accumulated outputs. It presents C = A×B through a valid/ready result handshake. The array and its PEs sit on the other side of this block.

## Interface
- WIDTH, 8, operand element width; results are 2*WIDTH.
- clk  in  1  sole clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand write request.
- in_ready  out  1  high only in IDLE.
- in_addr  in  3  0–3 = A[0][0],A[0][1],A[1][0],A[1][1]; 4–7 = B in the same row-major order.
- in_data  in  WIDTH  operand value, unsigned.
- start  in  1  single-cycle compute request.
- busy  out  1  high in CLEAR, FEED, DRAIN.
- arr_clr  out  1  active-high accumulator/pipeline clear to array PEs.
- a_data0, a_data1  out  WIDTH  row operand streams to array rows 0/1.
- b_data0, b_data1  out  WIDTH  column operand streams to array columns 0/1.
- c00_in, c01_in, c10_in, c11_in  in  2*WIDTH  array accumulator outputs.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed when high with res_valid.
- res_c00, res_c01, res_c10, res_c11  out  2*WIDTH  captured C elements.

## Operation
- Write: `in_valid & in_ready` stores in_data at in_addr and sets loaded[in_addr]. Rewriting an address overwrites it. Operands and the loaded mask persist across runs, so the same A/B can be rerun with start alone.
- Start is accepted in IDLE only when all 8 loaded bits are set, including a write completing in the same cycle. Otherwise start is ignored. Start outside IDLE is ignored.
- FSM: IDLE → CLEAR (1 cycle) → FEED (3 cycles, slot k=0..2) → DRAIN (2 cycles, slots 3,4) → DONE → IDLE on res handshake.
- CLEAR: arr_clr=1. All operand ports are 0.
- FEED schedule (slot k, value on ports during that cycle); every unlisted slot drives 0:
  - a_data0: k0 A[0][0], k1 A[0][1].
  - a_data1: k1 A[1][0], k2 A[1][1].
  - b_data0: k0 B[0][0], k1 B[1][0].
  - b_data1: k1 B[0][1], k2 B[1][1].
- DRAIN: all operand ports are 0. At the edge ending slot 4, c**_in are captured into res_c**.
- DONE: res_valid=1 and res_c** are held stable until `res_valid & res_ready`, then the FSM returns to IDLE.
- Arithmetic: the feeder does no arithmetic. Results are the array's unsigned 2*WIDTH accumulations, wrapping modulo 2^(2*WIDTH), captured unmodified.
- Operand ports are 0 in every state other than FEED.

## Timing
- Reset (async assert, any state): FSM=IDLE, loaded=0, stored operands=0. Outputs: in_ready=1, busy=0, arr_clr=0, res_valid=0, all a/b ports=0, all res_c**=0. Reset mid-FEED or mid-DRAIN abandons the run with no result.
- Array contract: the PE accumulates a_in*b_in at each edge and registers a_out/b_out/c_out. PE11's last product lands at the end of slot 3 and is visible on c11_in in slot 4.
- Latency: start accepted at edge E → CLEAR in cycle E+1, FEED E+2..E+4, DRAIN E+5..E+6, res_valid high from E+7.
- res_ready held high: DONE lasts one cycle. Back-to-back starts are separated by 8 cycles minimum.
- res_ready asserted while res_valid=0 has no effect.
- in_valid outside IDLE is not accepted (in_ready=0) and leaves the mask unchanged.

## Test plan
- Load A=[[1,2],[3,4]], B=[[5,6],[7,8]], start, res_ready=1 → res_c00=19, c01=22, c10=43, c11=50. res_valid rises exactly 7 cycles after the start edge and lasts 1 cycle.
- Start after loading only addresses 0–6 → no busy, no arr_clr, stays IDLE. Write addr 7 with start in the same cycle → run proceeds.
- All operands 255, WIDTH=8 → each res_c** = 130050 mod 65536 = 64514.
- Hold res_ready=0 for 5 cycles after res_valid → res_c** stable, in_ready=0, a second start ignored. The handshake then returns the FSM to IDLE.
- Rerun with only B overwritten to identity → C equals A without reloading A. Operand port sequence matches the schedule slot-by-slot, and zeros appear outside FEED.
- Assert rst low during FEED slot 1 → all outputs are reset values immediately. After release, start is ignored until all 8 operands are reloaded.

Source files
------------

// File: rtl/systolic_feeder_2x2.sv
// Operand scheduler and result collector for a 2x2 output-stationary systolic array.
// Loads A/B over a write port, streams skewed operands, and captures C = A x B.
module systolic_feeder_2x2 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_addr,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               start,
  output logic               busy,
  output logic               arr_clr,
  output logic [WIDTH-1:0]   a_data0,
  output logic [WIDTH-1:0]   a_data1,
  output logic [WIDTH-1:0]   b_data0,
  output logic [WIDTH-1:0]   b_data1,
  input  logic [2*WIDTH-1:0] c00_in,
  input  logic [2*WIDTH-1:0] c01_in,
  input  logic [2*WIDTH-1:0] c10_in,
  input  logic [2*WIDTH-1:0] c11_in,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] res_c00,
  output logic [2*WIDTH-1:0] res_c01,
  output logic [2*WIDTH-1:0] res_c10,
  output logic [2*WIDTH-1:0] res_c11
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       slot, slot_nxt;
  logic [WIDTH-1:0] opnd [8];
  logic [7:0]       loaded;
  logic             wr_en;
  logic [7:0]       wr_mask;
  logic             start_ok;

  assign wr_en   = in_valid & in_ready;
  assign wr_mask = wr_en ? (8'b1 << in_addr) : '0;
  // A write landing in the same cycle as start counts toward the full mask.
  assign start_ok = start && (state == S_IDLE) && (&(loaded | wr_mask));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      loaded <= '0;
      for (int unsigned i = 0; i < 8; i++) opnd[i] <= '0;
    end else if (wr_en) begin
      opnd[in_addr] <= in_data;
      loaded        <= loaded | wr_mask;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      slot  <= '0;
    end else begin
      state <= state_nxt;
      slot  <= slot_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          state_nxt = S_CLEAR;
          slot_nxt  = '0;
        end
      end
      S_CLEAR: begin
        state_nxt = S_FEED;
        slot_nxt  = '0;
      end
      S_FEED: begin
        slot_nxt = slot + 3'd1;
        if (slot == 3'd2) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        slot_nxt = slot + 3'd1;
        if (slot == 3'd4) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (res_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    busy      = (state == S_CLEAR) || (state == S_FEED) || (state == S_DRAIN);
    arr_clr   = (state == S_CLEAR);
    res_valid = (state == S_DONE);
    a_data0   = '0;
    a_data1   = '0;
    b_data0   = '0;
    b_data1   = '0;
    // Row 1 / column 1 run one slot behind row 0 / column 0 to match the array skew.
    if (state == S_FEED) begin
      case (slot)
        3'd0: begin
          a_data0 = opnd[0];
          b_data0 = opnd[4];
        end
        3'd1: begin
          a_data0 = opnd[1];
          a_data1 = opnd[2];
          b_data0 = opnd[6];
          b_data1 = opnd[5];
        end
        3'd2: begin
          a_data1 = opnd[3];
          b_data1 = opnd[7];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_c00 <= '0;
      res_c01 <= '0;
      res_c10 <= '0;
      res_c11 <= '0;
    end else if (state == S_DRAIN && slot == 3'd4) begin
      res_c00 <= c00_in;
      res_c01 <= c01_in;
      res_c10 <= c10_in;
      res_c11 <= c11_in;
    end
  end

endmodule

// File: tb/tb_systolic_feeder_2x2.sv
// Directed bench for systolic_feeder_2x2 with a behavioural 2x2 PE array on the far side.
module tb_systolic_feeder_2x2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_addr;
  logic [7:0]  in_data;
  logic        start;
  logic        busy;
  logic        arr_clr;
  logic [7:0]  a_data0, a_data1, b_data0, b_data1;
  logic [15:0] c00_in, c01_in, c10_in, c11_in;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_c00, res_c01, res_c10, res_c11;

  int checks = 0;
  int errors = 0;

  logic [7:0] a_m [4];
  logic [7:0] b_m [4];

  systolic_feeder_2x2 #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .start(start), .busy(busy), .arr_clr(arr_clr),
    .a_data0(a_data0), .a_data1(a_data1), .b_data0(b_data0), .b_data1(b_data1),
    .c00_in(c00_in), .c01_in(c01_in), .c10_in(c10_in), .c11_in(c11_in),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_c00(res_c00), .res_c01(res_c01), .res_c10(res_c10), .res_c11(res_c11)
  );

  always #5 clk = ~clk;

  // Output-stationary array: operands flow right (a) and down (b), one register per hop.
  logic [7:0] a_out00, a_out10, b_out00, b_out01;
  always @(posedge clk or negedge rst) begin
    if (!rst || arr_clr) begin
      c00_in <= '0; c01_in <= '0; c10_in <= '0; c11_in <= '0;
      a_out00 <= '0; a_out10 <= '0; b_out00 <= '0; b_out01 <= '0;
    end else begin
      c00_in  <= c00_in + 16'(a_data0 * b_data0);
      c01_in  <= c01_in + 16'(a_out00 * b_data1);
      c10_in  <= c10_in + 16'(a_data1 * b_out00);
      c11_in  <= c11_in + 16'(a_out10 * b_out01);
      a_out00 <= a_data0;
      a_out10 <= a_data1;
      b_out00 <= b_data0;
      b_out01 <= b_data1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_op(input logic [2:0] addr, input logic [7:0] data);
    in_valid = 1'b1;
    in_addr  = addr;
    in_data  = data;
    if (addr < 3'd4) a_m[addr[1:0]] = data;
    else             b_m[addr[1:0]] = data;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load_all(input logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3);
    write_op(3'd0, a0); write_op(3'd1, a1); write_op(3'd2, a2); write_op(3'd3, a3);
    write_op(3'd4, b0); write_op(3'd5, b1); write_op(3'd6, b2); write_op(3'd7, b3);
  endtask

  function automatic logic [31:0] ports();
    return {a_data0, a_data1, b_data0, b_data1};
  endfunction

  task automatic run_check(input logic [15:0] e00, e01, e10, e11,
                           input bit hold, input bit wr7, input logic [7:0] d7);
    logic [31:0] exp_p [3];
    if (wr7) begin
      in_valid = 1'b1; in_addr = 3'd7; in_data = d7; b_m[3] = d7;
    end
    res_ready = !hold;
    start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b0;
    exp_p[0] = {a_m[0], 8'd0,   b_m[0], 8'd0};
    exp_p[1] = {a_m[1], a_m[2], b_m[2], b_m[1]};
    exp_p[2] = {8'd0,   a_m[3], 8'd0,   b_m[3]};
    check("clear_arr_clr", arr_clr, 1);
    check("clear_busy", busy, 1);
    check("clear_ports", ports(), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("feed_slot%0d_ports", k), ports(), exp_p[k]);
      check($sformatf("feed_slot%0d_arr_clr", k), arr_clr, 0);
    end
    tick();
    check("drain3_ports", ports(), 0);
    check("drain3_res_valid", res_valid, 0);
    tick();
    check("drain4_ports", ports(), 0);
    check("drain4_res_valid", res_valid, 0);
    tick();
    check("done_res_valid_at_7", res_valid, 1);
    check("done_busy", busy, 0);
    check("res_c00", res_c00, e00);
    check("res_c01", res_c01, e01);
    check("res_c10", res_c10, e10);
    check("res_c11", res_c11, e11);
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        start = (i == 2);
        tick();
        check("hold_res_valid", res_valid, 1);
        check("hold_in_ready", in_ready, 0);
        check("hold_busy", busy, 0);
        check("hold_results", {res_c00, res_c11}, {e00, e11});
      end
      start = 1'b0;
      res_ready = 1'b1;
    end
    tick();
    check("after_hs_res_valid", res_valid, 0);
    check("after_hs_in_ready", in_ready, 1);
    check("after_hs_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0; start = 1'b0; res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin a_m[i] = '0; b_m[i] = '0; end
    tick(); tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_arr_clr", arr_clr, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_ports", ports(), 0);
    check("rst_res", {res_c00, res_c01}, 0);
    rst = 1'b1;
    tick();

    load_all(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
    run_check(16'd19, 16'd22, 16'd43, 16'd50, 1'b0, 1'b0, 8'd0);
    run_check(16'd19, 16'd22, 16'd43, 16'd50, 1'b1, 1'b0, 8'd0);

    write_op(3'd4, 8'd1); write_op(3'd5, 8'd0); write_op(3'd6, 8'd0); write_op(3'd7, 8'd1);
    run_check(16'd1, 16'd2, 16'd3, 16'd4, 1'b0, 1'b0, 8'd0);

    load_all(8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
    run_check(16'd64514, 16'd64514, 16'd64514, 16'd64514, 1'b0, 1'b0, 8'd0);

    // Abort a run in FEED slot 1.
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check("pre_abort_slot1_a0", a_data0, 255);
    #2 rst = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_res_valid", res_valid, 0);
    check("abort_ports", ports(), 0);
    check("abort_res", {res_c00, res_c11}, 0);
    for (int i = 0; i < 4; i++) begin a_m[i] = '0; b_m[i] = '0; end
    tick();
    rst = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    check("unloaded_start_busy", busy, 0);
    check("unloaded_start_in_ready", in_ready, 1);

    write_op(3'd0, 8'd1); write_op(3'd1, 8'd2); write_op(3'd2, 8'd3); write_op(3'd3, 8'd4);
    write_op(3'd4, 8'd5); write_op(3'd5, 8'd6); write_op(3'd6, 8'd7);
    start = 1'b1; tick(); start = 1'b0;
    check("partial_start_busy", busy, 0);
    check("partial_start_arr_clr", arr_clr, 0);
    tick();
    check("partial_still_idle", in_ready, 1);
    run_check(16'd19, 16'd22, 16'd43, 16'd50, 1'b0, 1'b1, 8'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0 expected=1");
    $fatal(1, "timeout");
  end

endmodule
